// File: rtl/negacyclic_pointwise_post.sv
// Post-NTT stage: pairs NTT-mode packets (A, B) into a lane-wise modular product C that is fed back
// as an iNTT packet, and scales/untwists iNTT-mode packets into the final result R. One serial lane
// engine processes one lane per cycle through a registered modular multiplier.
module negacyclic_pointwise_post #(
  parameter int unsigned    W         = 100,
  parameter int unsigned    N         = 8,
  parameter logic [W-1:0]   Modulus_Q = W'(64'd2147483777),
  parameter logic [W-1:0]   PSI_INV   = W'(64'd2145878094),
  parameter logic [W-1:0]   N_INV     = W'(64'd1879048305)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ntt_valid_in,
  input  logic                  ntt_mode_in,
  input  logic [N-1:0][W-1:0]   ntt_data_in,
  output logic                  fb_valid_out,
  output logic                  fb_mode_out,
  output logic [N-1:0][W-1:0]   fb_data_out,
  output logic                  res_valid_out,
  output logic [N-1:0][W-1:0]   res_data_out,
  output logic                  a_held,
  output logic                  busy,
  output logic                  overflow_err
);

  localparam int unsigned LaneW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW  = $clog2(N + 1);
  // Counter value of the completion cycle: all N lane products have been produced.
  localparam logic [CntW-1:0] CntDone = CntW'(N);

  typedef enum logic [1:0] {
    StIdle,
    StHoldA,
    StMul,
    StScale
  } state_e;

  state_e r_state;
  state_e w_state_d;

  logic [N-1:0][W-1:0] r_a_buf;
  logic [N-1:0][W-1:0] r_op;
  logic [N-1:0][W-1:0] r_acc;
  logic [N-1:0][W-1:0] r_fb_data;
  logic [N-1:0][W-1:0] r_res_data;
  logic [W-1:0]        r_prod;
  logic [W-1:0]        r_k;
  logic [CntW-1:0]     r_cnt;
  logic                r_a_held;
  logic                r_ovf;
  logic                r_fb_valid;
  logic                r_res_valid;

  logic                w_busy;
  logic                w_done;
  logic                w_accept;
  logic                w_capture_a;
  logic                w_start;
  logic [LaneW-1:0]    w_lane;
  logic [LaneW-1:0]    w_wb_lane;
  logic [W-1:0]        w_mul_a;
  logic [W-1:0]        w_mul_b;
  logic [2*W-1:0]      w_prod_full;
  logic [W-1:0]        w_prod_mod;
  logic [2*W-1:0]      w_k_full;
  logic [W-1:0]        w_k_next;
  logic [N-1:0][W-1:0] w_result;

  assign w_busy      = (r_state == StMul) || (r_state == StScale);
  assign w_done      = w_busy && (r_cnt == CntDone);
  assign w_accept    = ntt_valid_in && !w_busy;
  // In IDLE a mode-0 packet becomes A; anything else accepted starts the lane engine.
  assign w_capture_a = w_accept && (r_state == StIdle) && !ntt_mode_in;
  assign w_start     = w_accept && ((r_state == StHoldA) || ntt_mode_in);

  assign w_lane      = LaneW'(r_cnt);
  // Product register holds the lane processed one cycle earlier.
  assign w_wb_lane   = LaneW'(r_cnt - CntW'(1));

  // Lane multiplier: A*B in MUL, X*k in SCALE; full 2W-bit product reduced by one modulo.
  assign w_mul_a     = (r_state == StMul) ? r_a_buf[w_lane] : r_k;
  assign w_mul_b     = r_op[w_lane];
  assign w_prod_full = {{W{1'b0}}, w_mul_a} * {{W{1'b0}}, w_mul_b};
  assign w_prod_mod  = W'(w_prod_full % {{W{1'b0}}, Modulus_Q});

  // Twiddle-chain multiplier: k_{i+1} = k_i * PSI_INV mod Q.
  assign w_k_full    = {{W{1'b0}}, r_k} * {{W{1'b0}}, PSI_INV};
  assign w_k_next    = W'(w_k_full % {{W{1'b0}}, Modulus_Q});

  // Completed result vector: accumulated lanes plus the last lane still in the product register.
  always_comb begin
    w_result        = r_acc;
    w_result[N-1]   = r_prod;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next-state logic; packets arriving while busy never change state.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (ntt_valid_in) w_state_d = ntt_mode_in ? StScale : StHoldA;
      end
      StHoldA: begin
        if (ntt_valid_in) w_state_d = ntt_mode_in ? StScale : StMul;
      end
      StMul: begin
        if (w_done) w_state_d = StIdle;
      end
      StScale: begin
        if (w_done) w_state_d = r_a_held ? StHoldA : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Datapath: operand capture, lane engine, result load and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a_buf     <= '0;
      r_op        <= '0;
      r_acc       <= '0;
      r_fb_data   <= '0;
      r_res_data  <= '0;
      r_prod      <= '0;
      r_k         <= '0;
      r_cnt       <= '0;
      r_a_held    <= 1'b0;
      r_ovf       <= 1'b0;
      r_fb_valid  <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_fb_valid  <= 1'b0;
      r_res_valid <= 1'b0;

      if (ntt_valid_in && w_busy) begin
        r_ovf <= 1'b1;
      end

      if (w_capture_a) begin
        r_a_buf  <= ntt_data_in;
        r_a_held <= 1'b1;
      end

      if (w_start) begin
        r_op  <= ntt_data_in;
        r_cnt <= '0;
        r_k   <= N_INV;
      end

      if (w_busy) begin
        if (r_cnt != CntDone) begin
          r_prod <= w_prod_mod;
          r_k    <= w_k_next;
          r_cnt  <= r_cnt + CntW'(1);
        end
        if (r_cnt != '0) begin
          r_acc[w_wb_lane] <= r_prod;
        end
        if (w_done) begin
          if (r_state == StMul) begin
            r_fb_data  <= w_result;
            r_fb_valid <= 1'b1;
            r_a_held   <= 1'b0;
          end else begin
            r_res_data  <= w_result;
            r_res_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign fb_valid_out  = r_fb_valid;
  assign fb_mode_out   = r_fb_valid;
  assign fb_data_out   = r_fb_data;
  assign res_valid_out = r_res_valid;
  assign res_data_out  = r_res_data;
  assign a_held        = r_a_held;
  assign busy          = w_busy;
  assign overflow_err  = r_ovf;

endmodule

// File: tb/tb_negacyclic_pointwise_post.sv
// Bench for negacyclic_pointwise_post: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (accept/drop windows, expected strobes with their data).
`timescale 1ns/1ps
module tb_negacyclic_pointwise_post;

  localparam int unsigned W = 100;
  localparam int unsigned N = 8;
  localparam longint unsigned Q    = 64'd2147483777;
  localparam longint unsigned PSI  = 64'd2145878094;
  localparam longint unsigned NINV = 64'd1879048305;

  typedef logic [N-1:0][W-1:0] pkt_t;
  typedef struct {
    int   cyc;
    pkt_t data;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic ntt_valid_in;
  logic ntt_mode_in;
  pkt_t ntt_data_in;
  logic fb_valid_out;
  logic fb_mode_out;
  pkt_t fb_data_out;
  logic res_valid_out;
  pkt_t res_data_out;
  logic a_held;
  logic busy;
  logic overflow_err;

  always #5 clk = ~clk;

  negacyclic_pointwise_post dut (
    .clk           (clk),
    .reset         (reset),
    .ntt_valid_in  (ntt_valid_in),
    .ntt_mode_in   (ntt_mode_in),
    .ntt_data_in   (ntt_data_in),
    .fb_valid_out  (fb_valid_out),
    .fb_mode_out   (fb_mode_out),
    .fb_data_out   (fb_data_out),
    .res_valid_out (res_valid_out),
    .res_data_out  (res_data_out),
    .a_held        (a_held),
    .busy          (busy),
    .overflow_err  (overflow_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned mulmod(input longint unsigned a, input longint unsigned b);
    return (a * b) % Q;
  endfunction

  function automatic pkt_t fill(input longint unsigned v);
    pkt_t p;
    for (int i = 0; i < N; i++) p[i] = W'(v);
    return p;
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    for (int i = 0; i < N; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0)      p[i] = '0;
      else if (r == 1) p[i] = W'(Q - 1);
      else             p[i] = W'({32'd0, $urandom} % Q);
    end
    return p;
  endfunction

  // Reference model: transaction level, keyed on the edge number at which a packet is sampled.
  ev_t  fb_q[$];
  ev_t  res_q[$];
  int   cyc           = 0;
  bit   m_a_valid     = 1'b0;
  pkt_t m_a;
  int   m_start       = -100;
  int   m_ahold_until = -100;
  bit   m_ovf         = 1'b0;
  ev_t  m_ev;
  longint unsigned m_p;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      fb_q.delete();
      res_q.delete();
      m_a_valid     = 1'b0;
      m_start       = -100;
      m_ahold_until = -100;
      m_ovf         = 1'b0;
    end else if (ntt_valid_in) begin
      if (cyc > m_start && cyc <= m_start + int'(N) + 1) begin
        m_ovf = 1'b1;
      end else if (!ntt_mode_in && !m_a_valid) begin
        m_a       = ntt_data_in;
        m_a_valid = 1'b1;
      end else begin
        m_start  = cyc;
        m_ev.cyc = cyc + int'(N) + 1;
        if (!ntt_mode_in) begin
          for (int i = 0; i < N; i++)
            m_ev.data[i] = W'(mulmod(m_a[i][63:0], ntt_data_in[i][63:0]));
          fb_q.push_back(m_ev);
          m_a_valid     = 1'b0;
          m_ahold_until = cyc + int'(N) + 1;
        end else begin
          for (int i = 0; i < N; i++) begin
            m_p = 1;
            for (int j = 0; j < i; j++) m_p = mulmod(m_p, PSI);
            m_ev.data[i] = W'(mulmod(mulmod(ntt_data_in[i][63:0], NINV), m_p));
          end
          res_q.push_back(m_ev);
        end
      end
    end
  end

  // Per-cycle monitor, sampled on the falling edge.
  logic exp_fb;
  logic exp_res;
  logic exp_busy;
  logic exp_held;

  always @(negedge clk) begin
    if (cyc > 0) begin
      exp_fb   = (fb_q.size() > 0) && (fb_q[0].cyc == cyc);
      exp_res  = (res_q.size() > 0) && (res_q[0].cyc == cyc);
      exp_busy = (cyc >= m_start) && (cyc <= m_start + int'(N));
      exp_held = m_a_valid || (cyc < m_ahold_until);
      check_eq("fb_valid", W'(fb_valid_out), W'(exp_fb));
      check_eq("fb_mode", W'(fb_mode_out), W'(exp_fb));
      check_eq("res_valid", W'(res_valid_out), W'(exp_res));
      check_eq("busy", W'(busy), W'(exp_busy));
      check_eq("a_held", W'(a_held), W'(exp_held));
      check_eq("overflow_err", W'(overflow_err), W'(m_ovf));
      if (exp_fb) begin
        if (fb_valid_out)
          for (int i = 0; i < N; i++) check_eq($sformatf("fb_data[%0d]", i), fb_data_out[i],
                                               fb_q[0].data[i]);
        void'(fb_q.pop_front());
      end
      if (exp_res) begin
        if (res_valid_out)
          for (int i = 0; i < N; i++) check_eq($sformatf("res_data[%0d]", i), res_data_out[i],
                                               res_q[0].data[i]);
        void'(res_q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic m, input pkt_t d);
    @(negedge clk);
    #1;
    ntt_valid_in = v;
    ntt_mode_in  = m;
    ntt_data_in  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  initial begin
    reset        = 1'b0;
    ntt_valid_in = 1'b0;
    ntt_mode_in  = 1'b0;
    ntt_data_in  = '0;

    // Reset held for three cycles: every output is zero.
    idle(3);
    for (int i = 0; i < N; i++) begin
      check_eq("rst_fb_data", fb_data_out[i], '0);
      check_eq("rst_res_data", res_data_out[i], '0);
    end
    reset = 1'b1;
    idle(2);

    // Pointwise product, A then B on consecutive cycles.
    drive(1'b1, 1'b0, fill(2));
    drive(1'b1, 1'b0, fill(3));
    idle(14);
    for (int i = 0; i < N; i++) check_eq("t2_fb_data", fb_data_out[i], W'(6));

    // Scale and untwist of an all-8 packet.
    drive(1'b1, 1'b1, fill(8));
    idle(14);
    check_eq("t3_res0", res_data_out[0], W'(1));
    check_eq("t3_res1", res_data_out[1], W'(PSI));

    // Third packet two cycles after B is dropped.
    drive(1'b1, 1'b0, fill(2));
    drive(1'b1, 1'b0, fill(3));
    idle(1);
    drive(1'b1, 1'b0, fill(5));
    idle(14);
    check_eq("t4_overflow", W'(overflow_err), W'(1));
    for (int i = 0; i < N; i++) check_eq("t4_fb_data", fb_data_out[i], W'(6));

    // Interleave: A, then an iNTT packet, then B.
    drive(1'b1, 1'b0, rand_pkt());
    idle(4);
    drive(1'b1, 1'b1, rand_pkt());
    idle(14);
    check_eq("t5_a_held", W'(a_held), W'(1));
    drive(1'b1, 1'b0, rand_pkt());
    idle(14);

    // Reset while the multiplier is working on lane 4.
    drive(1'b1, 1'b0, rand_pkt());
    drive(1'b1, 1'b0, rand_pkt());
    idle(4);
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    check_eq("t7_busy", W'(busy), W'(0));
    check_eq("t7_a_held", W'(a_held), W'(0));
    idle(14);

    // Random traffic with collisions, drops and interleaving.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0) drive(1'b1, 1'($urandom_range(0, 1)), rand_pkt());
      else                           idle(1);
    end
    idle(16);
    check_eq("pending_fb", W'(fb_q.size()), W'(0));
    check_eq("pending_res", W'(res_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
